// File: rtl/vend_purchase_engine.sv
// Multi-slot vending purchase engine: handshake accept, CHECK, RESP commit.
// Optional accumulator saturation: define VEND_ACC_SAT_EN.
module vend_purchase_engine #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = 2,
  parameter int PRICE_W     = 4,
  parameter int QTY_W       = 4,
  parameter int MONEY_W     = 7,
  parameter int ACC_W       = 9,
  parameter int INIT_SUPPLY = 5,
  parameter int INIT_PRICE  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SLOT_W-1:0]  slot,
  input  logic [QTY_W-1:0]   amount,
  input  logic [MONEY_W-1:0] money,
  input  logic [PRICE_W-1:0] price_in,
  output logic               resp_valid,
  output logic               red_light,
  output logic [1:0]         reject_code,
  output logic [MONEY_W-1:0] remaining_money,
  output logic [QTY_W-1:0]   supply_out,
  output logic [ACC_W-1:0]   machine_acc,
  output logic               acc_sat
);

  localparam int CW = PRICE_W + QTY_W;
  localparam int MW = (MONEY_W > CW) ? MONEY_W : CW;

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t state, state_n;

  logic [1:0]         r_mode;
  logic [SLOT_W-1:0]  r_slot;
  logic [QTY_W-1:0]   r_amt;
  logic [MONEY_W-1:0] r_money;
  logic [PRICE_W-1:0] r_price;
  logic [CW-1:0]      cost_q;
  logic [1:0]         code_q;

  logic [PRICE_W-1:0] price_q  [NUM_SLOTS];
  logic [QTY_W-1:0]   supply_q [NUM_SLOTS];

  logic [31:0]        slot_ext;
  logic               slot_ok;
  logic [PRICE_W-1:0] cur_price;
  logic [QTY_W-1:0]   cur_supply;
  logic [CW-1:0]      cost_c;
  logic [1:0]         code_c;
  logic [QTY_W:0]     rs_sum;
  logic [QTY_W-1:0]   rs_val;
  logic               acc_add;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = CHECK;
      CHECK:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign slot_ext = 32'(r_slot);
  assign slot_ok  = slot_ext < 32'(NUM_SLOTS);

  always_comb begin
    cur_price  = '0;
    cur_supply = '0;
    if (slot_ok) begin
      cur_price  = price_q[r_slot];
      cur_supply = supply_q[r_slot];
    end
  end

  assign cost_c = CW'(cur_price) * CW'(r_amt);
  assign rs_sum = {1'b0, cur_supply} + {1'b0, r_amt};
  assign rs_val = rs_sum[QTY_W] ? '1 : rs_sum[QTY_W-1:0];

  // Bad slot outranks money, which outranks supply.
  always_comb begin
    code_c = 2'b00;
    if (!slot_ok)
      code_c = 2'b11;
    else if (r_mode == 2'b01) begin
      if (MW'(r_money) < MW'(cost_c)) code_c = 2'b01;
      else if (r_amt > cur_supply)    code_c = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode          <= '0;
      r_slot          <= '0;
      r_amt           <= '0;
      r_money         <= '0;
      r_price         <= '0;
      cost_q          <= '0;
      code_q          <= '0;
      resp_valid      <= 1'b0;
      red_light       <= 1'b0;
      reject_code     <= '0;
      remaining_money <= '0;
      supply_out      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        price_q[i]  <= PRICE_W'(INIT_PRICE);
        supply_q[i] <= QTY_W'(INIT_SUPPLY);
      end
    end else begin
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        r_mode  <= mode;
        r_slot  <= slot;
        r_amt   <= amount;
        r_money <= money;
        r_price <= price_in;
      end
      if (state == CHECK) begin
        cost_q <= cost_c;
        code_q <= code_c;
      end
      if (state == RESP) begin
        resp_valid      <= 1'b1;
        red_light       <= (code_q != 2'b00);
        reject_code     <= code_q;
        remaining_money <= r_money;
        supply_out      <= cur_supply;
        if (slot_ok) begin
          unique case (r_mode)
            2'b01: if (code_q == 2'b00) begin
              supply_q[r_slot] <= cur_supply - r_amt;
              supply_out       <= cur_supply - r_amt;
              remaining_money  <= r_money - MONEY_W'(cost_q);
            end
            2'b10: begin
              supply_q[r_slot] <= rs_val;
              supply_out       <= rs_val;
            end
            2'b11: price_q[r_slot] <= r_price;
            default: ;
          endcase
        end
      end
    end
  end

  assign acc_add = (state == RESP) && (r_mode == 2'b01) && (code_q == 2'b00);

`ifdef VEND_ACC_SAT_EN
  localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;
  localparam logic [SW-1:0] ACC_MAX = (SW'(1) << ACC_W) - SW'(1);

  logic [SW-1:0] acc_sum;

  assign acc_sum = SW'(machine_acc) + SW'(cost_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      machine_acc <= '0;
      acc_sat     <= 1'b0;
    end else if (acc_add) begin
      if (acc_sum > ACC_MAX) begin
        machine_acc <= '1;
        acc_sat     <= 1'b1;
      end else begin
        machine_acc <= acc_sum[ACC_W-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          machine_acc <= '0;
    else if (acc_add) machine_acc <= machine_acc + ACC_W'(cost_q);
  end

  assign acc_sat = 1'b0;
`endif

endmodule

// File: tb/tb_vend_purchase_engine.sv
// Randomised self-checking bench for vend_purchase_engine.
// Reference model tracks slot tables and money per transaction.
module tb_vend_purchase_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] slot;
  logic [3:0] amount;
  logic [6:0] money;
  logic [3:0] price_in;
  logic       resp_valid;
  logic       red_light;
  logic [1:0] reject_code;
  logic [6:0] remaining_money;
  logic [3:0] supply_out;
  logic [8:0] machine_acc;
  logic       acc_sat;

  int total = 0;
  int bad   = 0;

  int sup_m [4];
  int prc_m [4];
  int acc_m;
  bit sat_m;

  vend_purchase_engine dut (
    .clk             (clk),
    .rst             (rst),
    .mode            (mode),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .slot            (slot),
    .amount          (amount),
    .money           (money),
    .price_in        (price_in),
    .resp_valid      (resp_valid),
    .red_light       (red_light),
    .reject_code     (reject_code),
    .remaining_money (remaining_money),
    .supply_out      (supply_out),
    .machine_acc     (machine_acc),
    .acc_sat         (acc_sat)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sup_m[i] = 5;
      prc_m[i] = 3;
    end
    acc_m = 0;
    sat_m = 0;
  endtask

  task automatic model_apply(input int m, input int s, input int a,
                             input int mo, input int p,
                             output int code, output int rem,
                             output int so);
    int cost;
    code = 0;
    rem  = mo;
    so   = 0;
    if (s >= 4) begin
      code = 3;
      return;
    end
    cost = prc_m[s] * a;
    case (m)
      1: begin
        if (mo < cost) code = 1;
        else if (a > sup_m[s]) code = 2;
        else begin
          sup_m[s] -= a;
          rem = mo - cost;
`ifdef VEND_ACC_SAT_EN
          if (acc_m + cost > 511) begin
            acc_m = 511;
            sat_m = 1;
          end else acc_m += cost;
`else
          acc_m = (acc_m + cost) % 512;
`endif
        end
      end
      2: sup_m[s] = (sup_m[s] + a > 15) ? 15 : sup_m[s] + a;
      3: prc_m[s] = p;
      default: ;
    endcase
    so = sup_m[s];
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    mode      = '0;
    slot      = '0;
    amount    = '0;
    money     = '0;
    price_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_txn(input int m, input int s, input int a,
                         input int mo, input int p, input string tag);
    int ec, er, es, w;
    logic [24:0] exp_v;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_wait got=%b want=1", tag, req_ready);
    end
    mode      = m[1:0];
    slot      = s[1:0];
    amount    = a[3:0];
    money     = mo[6:0];
    price_in  = p[3:0];
    req_valid = 1'b1;
    model_apply(m, s, a, mo, p, ec, er, es);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mode      = 2'($urandom_range(0, 3));
    slot      = 2'($urandom_range(0, 3));
    amount    = 4'($urandom_range(0, 15));
    money     = 7'($urandom_range(0, 127));
    price_in  = 4'($urandom_range(0, 15));
    total++;
    if ({resp_valid, req_ready} !== 2'b00) begin
      bad++;
      $display("FAIL %s check_phase got=%b want=00", tag,
               {resp_valid, req_ready});
    end
    @(posedge clk);
    #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s early_resp got=%b want=0", tag, resp_valid);
    end
    @(posedge clk);
    #1;
    exp_v = {1'b1, ec != 0, 2'(ec), 7'(er), 4'(es), 9'(acc_m), sat_m};
    total++;
    if ({resp_valid, red_light, reject_code, remaining_money, supply_out,
         machine_acc, acc_sat} !== exp_v) begin
      bad++;
      $display("FAIL %s resp got=%h want=%h", tag,
               {resp_valid, red_light, reject_code, remaining_money,
                supply_out, machine_acc, acc_sat}, exp_v);
    end
    @(posedge clk);
    #1;
    exp_v[24] = 1'b0;
    total++;
    if ({resp_valid, red_light, reject_code, remaining_money, supply_out,
         machine_acc, acc_sat} !== exp_v) begin
      bad++;
      $display("FAIL %s hold got=%h want=%h", tag,
               {resp_valid, red_light, reject_code, remaining_money,
                supply_out, machine_acc, acc_sat}, exp_v);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({req_ready, resp_valid, red_light, reject_code, remaining_money,
         supply_out, machine_acc, acc_sat} !== 26'h2000000) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h",
               {req_ready, resp_valid, red_light, reject_code,
                remaining_money, supply_out, machine_acc, acc_sat},
               26'h2000000);
    end
    for (int i = 0; i < 4; i++) run_txn(0, i, 0, 0, 0, "reset_query");
    run_txn(1, 0, 1, 3, 0, "reset_price");
  endtask

  task automatic test_purchase_basic();
    do_reset();
    run_txn(1, 2, 3, 20, 0, "basic_buy");
    total++;
    if ({remaining_money, supply_out, machine_acc} !==
        {7'd11, 4'd2, 9'd9}) begin
      bad++;
      $display("FAIL basic_const got=%0d/%0d/%0d want=11/2/9",
               remaining_money, supply_out, machine_acc);
    end
  endtask

  task automatic test_rejects();
    run_txn(1, 0, 6, 100, 0, "rej_supply");
    total++;
    if ({red_light, reject_code, remaining_money, supply_out} !==
        {1'b1, 2'b10, 7'd100, 4'd5}) begin
      bad++;
      $display("FAIL rej_supply_const got=%b %b %0d %0d want=1 10 100 5",
               red_light, reject_code, remaining_money, supply_out);
    end
    run_txn(1, 1, 3, 8, 0, "rej_money");
    run_txn(1, 1, 3, 9, 0, "exact_money");
    total++;
    if ({reject_code, remaining_money} !== {2'b00, 7'd0}) begin
      bad++;
      $display("FAIL exact_money_const got=%b %0d want=00 0",
               reject_code, remaining_money);
    end
    run_txn(1, 1, 0, 0, 0, "zero_amount");
    run_txn(1, 1, 2, 6, 0, "drain_slot");
    run_txn(1, 1, 1, 50, 0, "empty_slot");
  endtask

  task automatic test_acc_overflow();
    do_reset();
    run_txn(3, 3, 0, 0, 15, "set_price");
    run_txn(2, 3, 15, 0, 0, "restock_sat");
    for (int k = 0; k < 5; k++) begin
      if (sup_m[3] < 8) run_txn(2, 3, 15, 0, 0, "restock");
      run_txn(1, 3, 8, 127, 0, "big_buy");
    end
    total++;
`ifdef VEND_ACC_SAT_EN
    if ({machine_acc, acc_sat} !== {9'd511, 1'b1}) begin
      bad++;
      $display("FAIL acc_sat_const got=%0d/%b want=511/1",
               machine_acc, acc_sat);
    end
`else
    if ({machine_acc, acc_sat} !== {9'd88, 1'b0}) begin
      bad++;
      $display("FAIL acc_wrap_const got=%0d/%b want=88/0",
               machine_acc, acc_sat);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 150; k++)
      run_txn($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 15), $urandom_range(0, 127),
              $urandom_range(0, 15), "random");
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    run_txn(1, 2, 1, 10, 0, "pre_abort");
    @(negedge clk);
    mode      = 2'b01;
    slot      = 2'd1;
    amount    = 4'd2;
    money     = 7'd20;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    seen      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    total++;
    if ({seen, req_ready, machine_acc} !== {1'b0, 1'b1, 9'd0}) begin
      bad++;
      $display("FAIL abort got=%b %b %0d want=0 1 0",
               seen, req_ready, machine_acc);
    end
    for (int i = 0; i < 4; i++) run_txn(0, i, 0, 0, 0, "abort_query");
  endtask

  task automatic test_back_to_back();
    int ec, er, es;
    logic [24:0] exp_v;
    do_reset();
    @(negedge clk);
    mode      = 2'b01;
    slot      = 2'd0;
    amount    = 4'd1;
    money     = 7'd50;
    req_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      total++;
      if (req_ready !== 1'((c % 3) == 0)) begin
        bad++;
        $display("FAIL b2b_ready c=%0d got=%b want=%b",
                 c, req_ready, (c % 3) == 0);
      end
      @(posedge clk);
      #1;
      if ((c % 3) == 2) begin
        model_apply(1, 0, 1, 50, 0, ec, er, es);
        exp_v = {1'b1, ec != 0, 2'(ec), 7'(er), 4'(es), 9'(acc_m), sat_m};
        total++;
        if ({resp_valid, red_light, reject_code, remaining_money,
             supply_out, machine_acc, acc_sat} !== exp_v) begin
          bad++;
          $display("FAIL b2b_resp c=%0d got=%h want=%h", c,
                   {resp_valid, red_light, reject_code, remaining_money,
                    supply_out, machine_acc, acc_sat}, exp_v);
        end
      end else begin
        total++;
        if (resp_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_idle c=%0d got=%b want=0", c, resp_valid);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_purchase_basic();
    test_rejects();
    test_acc_overflow();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_purchase_engine.md
# vend_purchase_engine

Parametrised multi-slot purchase engine for the vending machine. It owns the per-slot supply and price tables and the machine money accumulator internally, instead of taking them from an external array. Each transaction (purchase, restock or set-price) is accepted through a valid/ready handshake and answered with a single-cycle response pulse. It replaces the single-slot, single-cycle customer path and adds slot addressing, reject reasons, restocking and overflow handling.

## Interface
- `NUM_SLOTS`, 4, number of product slots (≥1)
- `SLOT_W`, 2, slot index width (≥ clog2(NUM_SLOTS), ≥1)
- `PRICE_W`, 4, price width per unit
- `QTY_W`, 4, supply / amount width
- `MONEY_W`, 7, customer money width
- `ACC_W`, 9, machine accumulator width
- `INIT_SUPPLY`, 5, per-slot supply after reset
- `INIT_PRICE`, 3, per-slot price after reset

Ports:
- `clk` in 1, system clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `mode` in 2, operation: 00 no-op, 01 purchase, 10 restock, 11 set price
- `req_valid` in 1, request present
- `req_ready` out 1, engine can accept a request
- `slot` in SLOT_W, target slot
- `amount` in QTY_W, units to buy (01) or units to add (10)
- `money` in MONEY_W, customer money (01); passed through for other modes
- `price_in` in PRICE_W, new unit price (11)
- `resp_valid` out 1, one-cycle response strobe
- `red_light` out 1, last transaction rejected
- `reject_code` out 2, 00 ok, 01 insufficient money, 10 insufficient supply, 11 bad slot
- `remaining_money` out MONEY_W, change returned
- `supply_out` out QTY_W, slot supply after the transaction
- `machine_acc` out ACC_W, accumulator value (always live)
- `acc_sat` out 1, sticky accumulator-saturated flag

## Operation
- FSM states: IDLE → CHECK → RESP → IDLE. `req_ready` = (state == IDLE).
- Accept happens on a rising edge with `req_valid && req_ready`. At accept, `mode`, `slot`, `amount`, `money` and `price_in` are latched. Input changes after the accept edge are ignored.
- CHECK stage:
  - Registers cost = price[slot] × amount, full width PRICE_W+QTY_W, no truncation.
  - Evaluates reject conditions in priority order: bad slot (slot ≥ NUM_SLOTS), then insufficient money, then insufficient supply.
- RESP stage: commits state changes, updates the outputs, and asserts `resp_valid` for one cycle.
- Purchase (01):
  - Succeeds when money ≥ cost and amount ≤ supply[slot].
  - On success: supply[slot] −= amount; acc += cost; remaining_money = money − cost; red_light = 0.
  - On reject: no table or accumulator change; remaining_money = money; red_light = 1.
  - Boundaries: amount 0 succeeds with cost 0 and no change. money == cost gives remaining 0. amount == supply leaves supply 0.
- Restock (10): supply[slot] = min(supply + amount, 2^QTY_W−1). Saturation is not a reject.
- Set price (11): price[slot] = price_in.
- For modes 00, 10 and 11: remaining_money = money. Bad slot gives code 11 and no write.
- For modes 10 and 11: red_light = 0 and code 00. `supply_out` reports the resulting supply. For a bad slot, `supply_out` = 0.
- `red_light`, `reject_code`, `remaining_money` and `supply_out` hold their values until the next RESP.

## Timing
- Accept at edge N. CHECK runs during cycle N→N+1. `resp_valid` is high between edges N+2 and N+3, and the outputs are valid in that same cycle.
- Back-to-back throughput: one transaction per 3 cycles. The next accept can occur at edge N+3.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `red_light` 0, `reject_code` 00, `remaining_money` 0, `supply_out` 0, `machine_acc` 0, `acc_sat` 0. All supplies = INIT_SUPPLY and all prices = INIT_PRICE.
- Reset asserted mid-transaction aborts it: no `resp_valid`, no commit. The tables are reinitialised.
- Accumulator wrap: modulo 2^ACC_W when saturation is compiled out.

## Configuration
- `VEND_ACC_SAT_EN` defined:
  - If acc + cost > 2^ACC_W−1, `machine_acc` clamps to all-ones and `acc_sat` is set.
  - `acc_sat` stays set until reset.
  - The purchase still succeeds for the customer.
- Undefined: the accumulator wraps and `acc_sat` is tied to 0.

## Test plan
- Reset, then purchase slot 2, amount 3, money 20 → `resp_valid` 2 cycles after accept; red_light 0, code 00, remaining_money 17−... correction: cost 9, so remaining_money 11, supply_out 2, machine_acc 9.
- Purchase slot 0, amount 6, money 100 (supply 5) → red_light 1, code 10, remaining_money 100, machine_acc unchanged, supply still 5.
- Purchase slot 1, amount 3, money 8 → code 01, remaining 8. Then money 9 → code 00, remaining 0.
- Set price slot 3 to 15; restock slot 3 with amount 15 → supply_out 15 (saturated). Run five successful purchases of cost 120 (restocking as needed):
  - Wrap build: machine_acc 88.
  - With `VEND_ACC_SAT_EN`: machine_acc 511, acc_sat 1.
- Assert `rst` during CHECK of a purchase → no `resp_valid`, machine_acc 0, all supplies 5, `req_ready` 1.
- Hold `req_valid` continuously → `req_ready` low in CHECK and RESP; accepts occur exactly every 3 cycles with one `resp_valid` per accept.
